// File: rtl/fetch_unit.sv
// fetch_unit: producer end of the instruction queue.
//
// Walks the PC, issues one I-cache read at a time, buffers the returned word
// with its PC and pushes the pair into the instruction queue once the queue
// has room. A redirect from the ROB reloads the PC, flushes the queue for one
// cycle and abandons whatever the I-cache is still working on.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   mem_i_read         I-cache read request, held until mem_i_resp
//   mem_i_address      I-cache read address, stable while mem_i_read is high
//   mem_i_rdata        instruction word, valid only with mem_i_resp
//   mem_i_resp         one-cycle read completion
//   iq_really_full     queue cannot accept a push this cycle
//   load_iq_fetch      push strobe into the queue
//   fetch_instruction  pushed instruction word (registered)
//   fetch_pc           PC of the pushed word (registered)
//   flush_iq_fetch     one-cycle queue flush (registered)
//   redirect           one-cycle redirect request from the ROB
//   redirect_pc        redirect target, sampled with redirect
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_i_read,
  output logic [31:0] mem_i_address,
  input  logic [31:0] mem_i_rdata,
  input  logic        mem_i_resp,
  input  logic        iq_really_full,
  output logic        load_iq_fetch,
  output logic [31:0] fetch_instruction,
  output logic [31:0] fetch_pc,
  output logic        flush_iq_fetch,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam logic [1:0] StFetch = 2'd0;  // read outstanding at pc
  localparam logic [1:0] StPush  = 2'd1;  // buffer holds a word waiting for the queue
  localparam logic [1:0] StDrop  = 2'd2;  // finishing an abandoned read at drop_addr

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic        flush_q, flush_d;

  // Outputs
  always_comb begin
    mem_i_read    = (state_q == StFetch) || (state_q == StDrop);
    // An abandoned read must keep its original address until the cache answers.
    mem_i_address = (state_q == StDrop) ? drop_addr_q : pc_q;
    load_iq_fetch = (state_q == StPush) && !iq_really_full && !redirect;
  end

  assign fetch_instruction = buf_instr_q;
  assign fetch_pc          = buf_pc_q;
  assign flush_iq_fetch    = flush_q;

  // Next state
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    drop_addr_d = drop_addr_q;
    flush_d     = redirect;

    if (redirect) begin
      pc_d = redirect_pc;
      unique case (state_q)
        StFetch: begin
          if (mem_i_resp) begin
            // Read completes this cycle; its data is simply not buffered.
            state_d = StFetch;
          end else begin
            drop_addr_d = pc_q;
            state_d     = StDrop;
          end
        end
        StPush: begin
          state_d = StFetch;
        end
        StDrop: begin
          // A response arriving now ends the abandoned read; otherwise keep draining.
          state_d = mem_i_resp ? StFetch : StDrop;
        end
        default: begin
          state_d = StFetch;
        end
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          if (mem_i_resp) begin
            buf_instr_d = mem_i_rdata;
            buf_pc_d    = pc_q;
            state_d     = StPush;
          end
        end
        StPush: begin
          if (!iq_really_full) begin
            pc_d    = pc_q + PC_STEP;
            state_d = StFetch;
          end
        end
        StDrop: begin
          if (mem_i_resp) begin
            state_d = StFetch;
          end
        end
        default: begin
          state_d = StFetch;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      drop_addr_q <= '0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      drop_addr_q <= drop_addr_d;
      flush_q     <= flush_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: one table row per clock cycle. Inputs of a row are
// driven just after the rising edge, outputs are checked on the falling edge.
// Responses that must reach the queue are pushed to a scoreboard and popped
// when load_iq_fetch is seen.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_i_read;
  logic [31:0] mem_i_address;
  logic [31:0] mem_i_rdata;
  logic        mem_i_resp;
  logic        iq_really_full;
  logic        load_iq_fetch;
  logic [31:0] fetch_instruction;
  logic [31:0] fetch_pc;
  logic        flush_iq_fetch;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .mem_i_read        (mem_i_read),
    .mem_i_address     (mem_i_address),
    .mem_i_rdata       (mem_i_rdata),
    .mem_i_resp        (mem_i_resp),
    .iq_really_full    (iq_really_full),
    .load_iq_fetch     (load_iq_fetch),
    .fetch_instruction (fetch_instruction),
    .fetch_pc          (fetch_pc),
    .flush_iq_fetch    (flush_iq_fetch),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc)
  );

  typedef struct packed {
    logic        rst;
    logic        resp;
    logic [31:0] rdata;
    logic        full;
    logic        redir;
    logic [31:0] rpc;
    logic        sb;      // this response must eventually be pushed
    logic        read;
    logic [31:0] addr;    // checked only when read is expected
    logic        load;
    logic        flush;
    logic        cbuf;    // check fetch_pc / fetch_instruction this row
    logic [31:0] fpc;
    logic [31:0] fin;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } push_t;

  vec_t  vecs[$];
  push_t sb_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    row      = 0;

  localparam logic [31:0] WA = 32'hA000_0001;
  localparam logic [31:0] WB = 32'hB000_0002;
  localparam logic [31:0] WC = 32'hC000_0003;
  localparam logic [31:0] WD = 32'hD000_0004;
  localparam logic [31:0] WE = 32'hE000_0005;
  localparam logic [31:0] WF = 32'hF000_0006;
  localparam logic [31:0] WG = 32'h1234_5678;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  task automatic add(input logic r, input logic resp, input logic [31:0] rdata,
                     input logic full, input logic redir, input logic [31:0] rpc,
                     input logic sb, input logic read, input logic [31:0] addr,
                     input logic load, input logic flush, input logic cbuf,
                     input logic [31:0] fpc, input logic [31:0] fin);
    vec_t v;
    v = '{rst: r, resp: resp, rdata: rdata, full: full, redir: redir, rpc: rpc, sb: sb,
          read: read, addr: addr, load: load, flush: flush, cbuf: cbuf, fpc: fpc, fin: fin};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    push_t p;
    // Buffered pushes in order, fresh after reset: buffer must read 0.
    //   rst resp rdata full rdr rpc       sb rd addr       ld fl cb fpc       fin
    // Plain stream 0x60, then 0x64 stalled by a full queue for 3 cycles, then 0x68.
    add(0, 1, WA,   0, 0, 32'h0,   1, 1, 32'h60,  0, 0, 1, 32'h0,   32'h0);
    add(0, 0, 0,    0, 0, 32'h0,   0, 0, 32'h0,   1, 0, 0, 32'h0,   32'h0);
    add(0, 1, WB,   0, 0, 32'h0,   1, 1, 32'h64,  0, 0, 0, 32'h0,   32'h0);
    add(0, 0, 0,    1, 0, 32'h0,   0, 0, 32'h0,   0, 0, 1, 32'h64,  WB);
    add(0, 0, 0,    1, 0, 32'h0,   0, 0, 32'h0,   0, 0, 1, 32'h64,  WB);
    add(0, 0, 0,    1, 0, 32'h0,   0, 0, 32'h0,   0, 0, 1, 32'h64,  WB);
    add(0, 0, 0,    0, 0, 32'h0,   0, 0, 32'h0,   1, 0, 0, 32'h0,   32'h0);
    add(0, 1, WC,   0, 0, 32'h0,   1, 1, 32'h68,  0, 0, 0, 32'h0,   32'h0);
    add(0, 0, 0,    0, 0, 32'h0,   0, 0, 32'h0,   1, 0, 0, 32'h0,   32'h0);
    // Redirect to 0x200 while the 0x6C read waits 4 cycles.
    add(0, 0, 0,    0, 1, 32'h200, 0, 1, 32'h6C,  0, 0, 0, 32'h0,   32'h0);
    add(0, 0, 0,    0, 0, 32'h0,   0, 1, 32'h6C,  0, 1, 0, 32'h0,   32'h0);
    add(0, 0, 0,    0, 0, 32'h0,   0, 1, 32'h6C,  0, 0, 0, 32'h0,   32'h0);
    add(0, 0, 0,    0, 0, 32'h0,   0, 1, 32'h6C,  0, 0, 0, 32'h0,   32'h0);
    add(0, 1, JUNK, 0, 0, 32'h0,   0, 1, 32'h6C,  0, 0, 0, 32'h0,   32'h0);
    add(0, 1, WD,   0, 0, 32'h0,   1, 1, 32'h200, 0, 0, 0, 32'h0,   32'h0);
    add(0, 0, 0,    0, 0, 32'h0,   0, 0, 32'h0,   1, 0, 0, 32'h0,   32'h0);
    // Redirect to 0x300 in the same cycle as a response.
    add(0, 1, JUNK, 0, 1, 32'h300, 0, 1, 32'h204, 0, 0, 0, 32'h0,   32'h0);
    add(0, 0, 0,    0, 0, 32'h0,   0, 1, 32'h300, 0, 1, 0, 32'h0,   32'h0);
    add(0, 1, WE,   0, 0, 32'h0,   0, 1, 32'h300, 0, 0, 0, 32'h0,   32'h0);
    // Redirect in PUSH, then two redirects while draining (0x400, 0x500).
    add(0, 0, 0,    0, 1, 32'h380, 0, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0);
    add(0, 0, 0,    0, 1, 32'h400, 0, 1, 32'h380, 0, 1, 0, 32'h0,   32'h0);
    add(0, 0, 0,    0, 1, 32'h500, 0, 1, 32'h380, 0, 1, 0, 32'h0,   32'h0);
    add(0, 0, 0,    0, 0, 32'h0,   0, 1, 32'h380, 0, 1, 0, 32'h0,   32'h0);
    add(0, 1, JUNK, 0, 0, 32'h0,   0, 1, 32'h380, 0, 0, 0, 32'h0,   32'h0);
    add(0, 1, WF,   0, 0, 32'h0,   1, 1, 32'h500, 0, 0, 0, 32'h0,   32'h0);
    add(0, 0, 0,    0, 0, 32'h0,   0, 0, 32'h0,   1, 0, 1, 32'h500, WF);
    // Steer to 0x80, then reset while that read is outstanding.
    add(0, 0, 0,    0, 1, 32'h80,  0, 1, 32'h504, 0, 0, 0, 32'h0,   32'h0);
    add(0, 1, JUNK, 0, 0, 32'h0,   0, 1, 32'h504, 0, 1, 0, 32'h0,   32'h0);
    add(0, 0, 0,    0, 0, 32'h0,   0, 1, 32'h80,  0, 0, 0, 32'h0,   32'h0);
    add(1, 0, 0,    0, 0, 32'h0,   0, 1, 32'h80,  0, 0, 0, 32'h0,   32'h0);
    add(0, 0, 0,    0, 0, 32'h0,   0, 1, 32'h60,  0, 0, 1, 32'h0,   32'h0);
    add(0, 1, WG,   0, 0, 32'h0,   1, 1, 32'h60,  0, 0, 0, 32'h0,   32'h0);
    add(0, 0, 0,    0, 0, 32'h0,   0, 0, 32'h0,   1, 0, 1, 32'h60,  WG);

    rst = 1'b1;
    mem_i_rdata = '0;
    mem_i_resp = 1'b0;
    iq_really_full = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      row = i;
      #1;
      rst            = vecs[i].rst;
      mem_i_resp     = vecs[i].resp;
      mem_i_rdata    = vecs[i].rdata;
      iq_really_full = vecs[i].full;
      redirect       = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      @(negedge clk);
      check("mem_i_read", {31'b0, mem_i_read}, {31'b0, vecs[i].read});
      if (vecs[i].read) check("mem_i_address", mem_i_address, vecs[i].addr);
      check("load_iq_fetch", {31'b0, load_iq_fetch}, {31'b0, vecs[i].load});
      check("flush_iq_fetch", {31'b0, flush_iq_fetch}, {31'b0, vecs[i].flush});
      if (vecs[i].cbuf) begin
        check("fetch_pc_held", fetch_pc, vecs[i].fpc);
        check("fetch_instr_held", fetch_instruction, vecs[i].fin);
      end
      if (vecs[i].sb) sb_q.push_back('{pc: vecs[i].addr, instr: vecs[i].rdata});
      if (load_iq_fetch === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_push row %0d: got pc %h expected no push", row, fetch_pc);
        end else begin
          p = sb_q.pop_front();
          check("push_pc", fetch_pc, p.pc);
          check("push_instr", fetch_instruction, p.instr);
        end
      end
      @(posedge clk);
    end

    check("pending_pushes", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
